// File: rtl/mult_control_unit.sv
// Sequencing FSM for the shift-add signed multiplier: clears A/X, then runs
// N_BITS add(or subtract)/shift pairs per Run press and holds the result until Run is released.
module mult_control_unit #(
    parameter int N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    // state | meaning
    // IDLE  | waiting for Run press; ClearA_LoadB drives Clr_Ld
    // CLRA  | clear A and X before the first iteration
    // ADD   | add S into A when M=1 (subtract on the final iteration)
    // SHIFT | arithmetic right shift X:A:B, advance iteration count
    // HOLD  | product valid, wait for Run release
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLRA  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_iter;

    assign last_iter = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!Run) state_d = S_CLRA;
            end
            S_CLRA: begin
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Exit on the last iteration so cnt never wraps.
                if (last_iter) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (Run) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        Clr_Ld = 1'b0;
        ClearA = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (state_q)
            S_IDLE:  Clr_Ld = ~ClearA_LoadB;
            S_CLRA: begin
                ClearA = 1'b1;
                Busy   = 1'b1;
            end
            S_ADD: begin
                Busy = 1'b1;
                Add  = M & ~last_iter;
                Sub  = M &  last_iter;
            end
            S_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            S_HOLD:  Done = 1'b1;
            default: ;
        endcase
    end

endmodule
